// File: rtl/eeprom_pkg.sv
// Shared types and constants for the I2C EEPROM emulator.
package eeprom_pkg;

  // One-hot FSM states; state_code() folds them to 3 bits for debug.
  typedef enum logic [6:0] {
    S_IDLE    = 7'b0000001,
    S_DEV     = 7'b0000010,
    S_ADDR_HI = 7'b0000100,
    S_ADDR_LO = 7'b0001000,
    S_WRITE   = 7'b0010000,
    S_READ    = 7'b0100000,
    S_IGNORE  = 7'b1000000
  } state_t;

  localparam logic [1:0] MODE_7BIT  = 2'd0;
  localparam logic [1:0] MODE_11BIT = 2'd1;
  localparam logic [1:0] MODE_16BIT = 2'd2;

  localparam logic [3:0] DEV_CODE = 4'b1010;

  function automatic logic [2:0] state_code(input state_t s);
    case (s)
      S_IDLE:    return 3'd0;
      S_DEV:     return 3'd1;
      S_ADDR_HI: return 3'd2;
      S_ADDR_LO: return 3'd3;
      S_WRITE:   return 3'd4;
      S_READ:    return 3'd5;
      S_IGNORE:  return 3'd6;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/i2c_bus_cond.sv
// I2C pin filter, START/STOP detection, bit counter and ACK-slot tracking.
module i2c_bus_cond #(
  parameter int FILT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       sda_i,
  input  logic       scl,
  output logic       start,
  output logic       stop,
  output logic       bit_fall,
  output logic       byte_done,
  output logic       ack_rise,
  output logic       ack_done,
  output logic       sda_lvl,
  output logic [2:0] bit_cnt,
  output logic [7:0] din
);

  localparam int H = FILT / 2;
  // Older samples low, newer samples high: a clean rising edge.
  localparam logic [FILT-1:0] RISE_PAT = {{(FILT-H){1'b0}}, {H{1'b1}}};
  localparam logic [FILT-1:0] FALL_PAT = ~RISE_PAT;

  logic [FILT-1:0] sda_sh, scl_sh;
  logic            last, in_ack;
  logic            scl_high, scl_rise, scl_fall, sda_rise, sda_fall;

  assign scl_high = &scl_sh;
  assign sda_lvl  = &sda_sh;
  assign scl_rise = en && (scl_sh == RISE_PAT);
  assign scl_fall = en && (scl_sh == FALL_PAT);
  assign sda_rise = en && (sda_sh == RISE_PAT);
  assign sda_fall = en && (sda_sh == FALL_PAT);

  assign start     = sda_fall && scl_high;
  assign stop      = sda_rise && scl_high;
  assign bit_fall  = scl_fall && !last && !in_ack;
  assign byte_done = scl_fall && last;
  assign ack_rise  = scl_rise && in_ack;
  assign ack_done  = scl_fall && in_ack;

  // Pin filter shift registers; idle bus reads as all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sda_sh <= '1;
      scl_sh <= '1;
    end else if (en) begin
      sda_sh <= {sda_sh[FILT-2:0], sda_i};
      scl_sh <= {scl_sh[FILT-2:0], scl};
    end
  end

  // Bit counter: 8 data rises mark the byte, next fall opens the ACK slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= 3'd7;
      last    <= 1'b0;
      in_ack  <= 1'b0;
    end else if (start || stop) begin
      bit_cnt <= 3'd7;
      last    <= 1'b0;
      in_ack  <= 1'b0;
    end else if (scl_rise && !in_ack) begin
      if (bit_cnt == 3'd0) last <= 1'b1;
      else                 bit_cnt <= bit_cnt - 3'd1;
    end else if (scl_fall) begin
      if (last) begin
        last   <= 1'b0;
        in_ack <= 1'b1;
      end else if (in_ack) begin
        in_ack  <= 1'b0;
        bit_cnt <= 3'd7;
      end
    end
  end

  // Data shifter, MSB first, sampled at filtered SCL rise.
  always_ff @(posedge clk) begin
    if (scl_rise && !in_ack) din <= {din[6:0], sda_lvl};
  end

endmodule

// File: rtl/eeprom_i2c_slave.sv
// I2C serial-EEPROM emulator: protocol FSM, address logic and save-RAM port.
module eeprom_i2c_slave
  import eeprom_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int PAGE_W = 4,
  parameter int FILT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] mask,
  input  logic              wp,
  input  logic              sda_i,
  input  logic              scl,
  output logic              sda_o,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_d,
  output logic              ram_wr,
  output logic              ram_rd,
  input  logic [7:0]        ram_q,
  output logic [2:0]        state_o
);

  localparam logic [15:0] AMASK = 16'((32'd1 << ADDR_W) - 32'd1);
  localparam logic [15:0] PMASK = 16'((32'd1 << PAGE_W) - 32'd1);

  state_t      state, state_n;
  logic [15:0] addr, addr_n;
  logic [7:0]  dout, din;
  logic [2:0]  bit_cnt;
  logic        sda_n, wr_n, rd_n, inc_n, inc_p, mslot, mslot_n;
  logic        vld_p1, vld_p2;
  logic        start, stop, bit_fall, byte_done, ack_rise, ack_done, sda_lvl;

  // Sequential reads roll over the whole RAM.
  function automatic logic [15:0] addr_inc(input logic [15:0] a);
    return (a + 16'd1) & AMASK;
  endfunction

  // Page writes only advance the in-page offset.
  function automatic logic [15:0] page_inc(input logic [15:0] a);
    return (a & ~PMASK) | ((a + 16'd1) & PMASK);
  endfunction

  i2c_bus_cond #(.FILT(FILT)) u_bus (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sda_i     (sda_i),
    .scl       (scl),
    .start     (start),
    .stop      (stop),
    .bit_fall  (bit_fall),
    .byte_done (byte_done),
    .ack_rise  (ack_rise),
    .ack_done  (ack_done),
    .sda_lvl   (sda_lvl),
    .bit_cnt   (bit_cnt),
    .din       (din)
  );

  assign ram_addr = addr[ADDR_W-1:0] & mask;
  assign state_o  = state_code(state);

  // Next-state, address and bus-drive decisions per bus event.
  always_comb begin
    state_n = state;
    addr_n  = addr;
    sda_n   = sda_o;
    wr_n    = 1'b0;
    rd_n    = 1'b0;
    inc_n   = 1'b0;
    mslot_n = mslot;
    if (inc_p) addr_n = page_inc(addr);
    if (start) begin
      state_n = S_DEV;
      sda_n   = 1'b1;
      mslot_n = 1'b0;
    end else if (stop) begin
      state_n = S_IDLE;
      sda_n   = 1'b1;
      mslot_n = 1'b0;
    end else if (byte_done) begin
      sda_n = 1'b1;
      case (state)
        S_DEV: begin
          if (mode == MODE_7BIT) addr_n[6:0] = din[7:1];
          if (mode != MODE_7BIT && din[7:4] != DEV_CODE) begin
            state_n = S_IGNORE;
          end else begin
            if (mode == MODE_11BIT) addr_n[10:8] = din[3:1];
            sda_n = 1'b0;
            if (din[0]) begin
              state_n = S_READ;
              rd_n    = 1'b1;
            end else if (mode == MODE_7BIT)  state_n = S_WRITE;
            else if (mode == MODE_11BIT)     state_n = S_ADDR_LO;
            else                             state_n = S_ADDR_HI;
          end
        end
        S_ADDR_HI: begin
          addr_n[15:8] = din;
          sda_n        = 1'b0;
          state_n      = S_ADDR_LO;
        end
        S_ADDR_LO: begin
          addr_n[7:0] = din;
          sda_n       = 1'b0;
          state_n     = S_WRITE;
        end
        S_WRITE: begin
          sda_n = 1'b0;
          wr_n  = ~wp;
          inc_n = 1'b1;
        end
        S_READ:  mslot_n = 1'b1;
        default: ;
      endcase
    end else if (ack_rise && mslot) begin
      if (!sda_lvl) begin
        addr_n = addr_inc(addr);
        rd_n   = 1'b1;
      end else begin
        state_n = S_IGNORE;
      end
    end else if (ack_done) begin
      mslot_n = 1'b0;
      sda_n   = (state == S_READ) ? dout[7] : 1'b1;
    end else if (bit_fall && state == S_READ) begin
      sda_n = dout[bit_cnt];
    end
  end

  // Control and strobe registers; ram_d captures each received write byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      addr   <= '0;
      sda_o  <= 1'b1;
      ram_wr <= 1'b0;
      ram_rd <= 1'b0;
      ram_d  <= '0;
      inc_p  <= 1'b0;
      mslot  <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (en) begin
      state  <= state_n;
      addr   <= addr_n;
      sda_o  <= sda_n;
      ram_wr <= wr_n;
      ram_rd <= rd_n;
      inc_p  <= inc_n;
      mslot  <= mslot_n;
      // read-latency stage 1 -> 2
      vld_p1 <= ram_rd;
      vld_p2 <= vld_p1;
      if (inc_n) ram_d <= din;
    end
  end

  // Read data lands two clocks after the ram_rd strobe.
  always_ff @(posedge clk) begin
    if (en && vld_p2) dout <= ram_q;
  end

endmodule

// File: tb/tb_eeprom_i2c_slave.sv
// Directed bench for eeprom_i2c_slave: bit-banged I2C master plus RAM model.
module tb_eeprom_i2c_slave;

  localparam int ADDR_W = 13;
  localparam int PAGE_W = 4;
  localparam int FILT   = 4;
  localparam int Q      = 12;

  logic              clk = 1'b0;
  logic              rst, en, wp;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] mask;
  logic              m_sda, m_scl, sda_bus;
  logic              sda_o, ram_wr, ram_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_d, ram_q, q1;
  logic [2:0]        state_o;

  logic [7:0]  mem [0:(1<<ADDR_W)-1];
  logic [15:0] wr_a[$];
  logic [7:0]  wr_d[$];
  logic [15:0] rd_a[$];

  int n_chk  = 0;
  int n_fail = 0;

  logic       ack, acks;
  logic [7:0] rd;

  assign sda_bus = m_sda & sda_o;

  always #5 clk = ~clk;

  eeprom_i2c_slave #(.ADDR_W(ADDR_W), .PAGE_W(PAGE_W), .FILT(FILT)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .mask     (mask),
    .wp       (wp),
    .sda_i    (sda_bus),
    .scl      (m_scl),
    .sda_o    (sda_o),
    .ram_addr (ram_addr),
    .ram_d    (ram_d),
    .ram_wr   (ram_wr),
    .ram_rd   (ram_rd),
    .ram_q    (ram_q),
    .state_o  (state_o)
  );

  // RAM model with two-clock read latency, plus strobe logging.
  always @(posedge clk) begin
    if (ram_rd) q1 <= mem[ram_addr];
    ram_q <= q1;
    if (ram_wr) begin
      wr_a.push_back(16'(ram_addr));
      wr_d.push_back(ram_d);
    end
    if (ram_rd) rd_a.push_back(16'(ram_addr));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; tick(Q);
      m_scl = 1'b1; tick(2*Q);
      m_scl = 1'b0; tick(Q);
    end
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    a = sda_bus;  tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1'b1; tick(Q);
      m_scl = 1'b1; tick(Q);
      d[i] = sda_bus; tick(Q);
      m_scl = 1'b0; tick(Q);
    end
    m_sda = mack; tick(Q);
    m_scl = 1'b1; tick(2*Q);
    m_scl = 1'b0; tick(Q);
    m_sda = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 8'(i) ^ 8'h3C;
    rst = 1'b1; en = 1'b1; wp = 1'b0; mode = 2'd0; mask = '1;
    m_sda = 1'b1; m_scl = 1'b1;
    tick(3);

    // Reset state
    check("rst_sda_o",   32'(sda_o),    32'h1);
    check("rst_state",   32'(state_o),  32'h0);
    check("rst_ram_wr",  32'(ram_wr),   32'h0);
    check("rst_ram_rd",  32'(ram_rd),   32'h0);
    check("rst_ram_addr",32'(ram_addr), 32'h0);
    check("rst_ram_d",   32'(ram_d),    32'h0);
    rst = 1'b0;
    tick(4*Q);

    // Mode 0 write: 0xA0, 5A, C3
    wr_a = {}; wr_d = {}; mode = 2'd0;
    bus_start();
    check("m0_state_dev", 32'(state_o), 32'h1);
    send_byte(8'hA0, ack); check("m0_ack_dev", 32'(ack), 32'h0);
    check("m0_state_wr", 32'(state_o), 32'h4);
    send_byte(8'h5A, ack); check("m0_ack_d0", 32'(ack), 32'h0);
    send_byte(8'hC3, ack); check("m0_ack_d1", 32'(ack), 32'h0);
    bus_stop();
    check("m0_state_idle", 32'(state_o), 32'h0);
    check("m0_wr_count", 32'(wr_a.size()), 32'd2);
    check("m0_wr_a0", 32'(wr_a[0]), 32'h50);
    check("m0_wr_d0", 32'(wr_d[0]), 32'h5A);
    check("m0_wr_a1", 32'(wr_a[1]), 32'h51);
    check("m0_wr_d1", 32'(wr_d[1]), 32'hC3);

    // Mode 2 page wrap from 0x012E
    wr_a = {}; wr_d = {}; mode = 2'd2; acks = 1'b0;
    bus_start();
    send_byte(8'hA0, ack); acks |= ack;
    check("m2_state_hi", 32'(state_o), 32'h2);
    send_byte(8'h01, ack); acks |= ack;
    check("m2_state_lo", 32'(state_o), 32'h3);
    send_byte(8'h2E, ack); acks |= ack;
    send_byte(8'h11, ack); acks |= ack;
    send_byte(8'h22, ack); acks |= ack;
    send_byte(8'h33, ack); acks |= ack;
    send_byte(8'h44, ack); acks |= ack;
    bus_stop();
    check("m2_acks", 32'(acks), 32'h0);
    check("m2_wr_count", 32'(wr_a.size()), 32'd4);
    check("m2_wr_a0", 32'(wr_a[0]), 32'h012E);
    check("m2_wr_a1", 32'(wr_a[1]), 32'h012F);
    check("m2_wr_a2", 32'(wr_a[2]), 32'h0120);
    check("m2_wr_a3", 32'(wr_a[3]), 32'h0121);
    check("m2_wr_d2", 32'(wr_d[2]), 32'h33);
    check("m2_wr_d3", 32'(wr_d[3]), 32'h44);

    // Mode 1 random read of block 3, offset 0x10
    wr_a = {}; rd_a = {}; mode = 2'd1; acks = 1'b0;
    bus_start();
    send_byte(8'hA6, ack); acks |= ack;
    send_byte(8'h10, ack); acks |= ack;
    bus_start();
    send_byte(8'hA7, ack); acks |= ack;
    check("m1_acks", 32'(acks), 32'h0);
    check("m1_state_rd", 32'(state_o), 32'h5);
    recv_byte(1'b0, rd); check("m1_rd0", 32'(rd), 32'h2C);
    recv_byte(1'b0, rd); check("m1_rd1", 32'(rd), 32'h2D);
    recv_byte(1'b1, rd); check("m1_rd2", 32'(rd), 32'h2E);
    check("m1_state_ign", 32'(state_o), 32'h6);
    check("m1_sda_rel0", 32'(sda_o), 32'h1);
    tick(3*Q);
    check("m1_sda_rel1", 32'(sda_o), 32'h1);
    bus_stop();
    check("m1_rd_count", 32'(rd_a.size()), 32'd3);
    check("m1_rd_a0", 32'(rd_a[0]), 32'h310);
    check("m1_rd_a2", 32'(rd_a[2]), 32'h312);
    check("m1_wr_count", 32'(wr_a.size()), 32'd0);

    // Mode 2 device-code mismatch
    wr_a = {}; rd_a = {}; mode = 2'd2;
    bus_start();
    send_byte(8'hB0, ack); check("dc_nack", 32'(ack), 32'h1);
    check("dc_state_ign", 32'(state_o), 32'h6);
    send_byte(8'h55, ack); check("dc_nack2", 32'(ack), 32'h1);
    bus_stop();
    check("dc_strobes", 32'(wr_a.size() + rd_a.size()), 32'd0);

    // Write protect, mode 0 at 0x52 with a 7-bit mask
    wr_a = {}; mode = 2'd0; wp = 1'b1; mask = 13'h007F; acks = 1'b0;
    bus_start();
    send_byte(8'hA4, ack); acks |= ack;
    send_byte(8'h01, ack); acks |= ack;
    send_byte(8'h02, ack); acks |= ack;
    bus_stop();
    check("wp_acks", 32'(acks), 32'h0);
    check("wp_wr_count", 32'(wr_a.size()), 32'd0);
    check("wp_addr_adv", 32'(ram_addr), 32'h54);
    wp = 1'b0; mask = '1;

    // Reset in the middle of a read byte (current address 0x354, data 0x68)
    rd_a = {}; wr_a = {}; wr_d = {}; mode = 2'd2;
    bus_start();
    send_byte(8'hA1, ack); check("rr_ack", 32'(ack), 32'h0);
    check("rr_rd_addr", 32'(rd_a[0]), 32'h354);
    check("rr_bit7_drv", 32'(sda_o), 32'h0);
    m_scl = 1'b1; tick(Q);
    @(posedge clk); #3;
    rst = 1'b1; #1;
    check("rr_async_sda", 32'(sda_o), 32'h1);
    check("rr_async_state", 32'(state_o), 32'h0);
    check("rr_async_rd", 32'(ram_rd), 32'h0);
    tick(2);
    rst = 1'b0; m_sda = 1'b1; m_scl = 1'b1;
    tick(4*Q);
    acks = 1'b0;
    bus_start();
    send_byte(8'hA0, ack); acks |= ack;
    send_byte(8'h00, ack); acks |= ack;
    send_byte(8'h05, ack); acks |= ack;
    send_byte(8'h77, ack); acks |= ack;
    bus_stop();
    check("rr_post_acks", 32'(acks), 32'h0);
    check("rr_post_count", 32'(wr_a.size()), 32'd1);
    check("rr_post_a", 32'(wr_a[0]), 32'h0005);
    check("rr_post_d", 32'(wr_d[0]), 32'h77);
    check("rr_post_idle", 32'(state_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
